dreg_snapshot_readout: RTL and testbench
========================================

Name: dreg_snapshot_readout

Overview:
- Downstream consumer stage for the per-clock multi-entry register array.
- Continuously records N-bit samples into an M-deep circular array [0:M-1].
- On a trigger, records POST more samples, then freezes the array.
- Streams the frozen contents oldest-first over a valid/ready port, then re-arms.

Parameters:
- N, 2, sample width in bits (>=1).
- M, 4, array depth in entries (>=2, any integer, not required to be a power of two).
- POST, 1, number of valid samples recorded after trigger acceptance (0..M-1).

Ports:
- clock  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- d  input  N  sample data.
- d_valid  input  1  sample strobe; d is written when high in CAPTURE or POST.
- trigger  input  1  single-cycle capture request.
- out_ready  input  1  consumer accepts out_data when high with out_valid.
- out_data  output  N  readout sample.
- out_valid  output  1  out_data valid.
- out_last  output  1  marks final readout entry; qualified by out_valid.
- out_index  output  clog2(M) (min 1)  position of entry in readout, 0 = oldest.
- busy  output  1  high in POST and READOUT.

Behaviour:
- Reset: synchronous, takes effect at the next posedge with reset high.
  - out_data, out_valid, out_last, out_index and busy all go to 0.
  - wr_ptr and fill count go to 0; state goes to CAPTURE.
  - Array contents are not cleared.
- Reset during READOUT: out_valid drops at that edge; no partial-transfer completion.
- States: CAPTURE -> POST -> READOUT -> CAPTURE.
- CAPTURE:
  - d_valid=1 writes array[wr_ptr] = d.
  - wr_ptr advances and wraps M-1 -> 0.
  - Fill count saturates at M.
  - trigger is accepted when fill count + d_valid >= 1.
    - If POST=0, accepting moves to READOUT.
    - Otherwise, accepting moves to POST with post_cnt = POST.
  - Trigger and d_valid in the same cycle: the sample is written and counts toward fill, not toward POST.
  - trigger with an empty buffer and no d_valid is ignored.
- POST:
  - Each d_valid write decrements post_cnt; fill count is still updated.
  - The write that brings post_cnt to 0 moves the block to READOUT at that edge.
  - trigger is ignored.
- READOUT:
  - The array is frozen; d_valid and trigger are ignored.
  - rd_ptr starts at (wr_ptr - fill) mod M; K = fill entries are emitted.
  - First out_valid is asserted 1 cycle after entering READOUT.
  - out_data, out_index and out_last are registered and hold stable while out_valid=1 and out_ready=0.
  - A transfer occurs when out_valid and out_ready are both high at a posedge.
    - Next entry is presented at that same edge (full throughput, 1 entry/cycle with out_ready tied high).
    - rd_ptr wraps M-1 -> 0.
  - out_last=1 only on index K-1.
  - The transfer of the last entry clears out_valid and returns the block to CAPTURE.
    - Fill count is cleared to 0; wr_ptr is retained.
- busy = (state != CAPTURE), registered.
- Arithmetic:
  - Pointers are modulo M using explicit compare-and-wrap, never bit truncation.
  - Fill count and post_cnt are clog2(M+1) bits wide.

Optional Feature:
- Macro: DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN.
- Defined:
  - Adds output port ignored_trig, 16 bits, reset 0.
  - Increments on each cycle trigger=1 is ignored: state POST or READOUT, or empty buffer in CAPTURE.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- N=8, M=4, POST=1: write 0x11,0x22,0x33,0x44,0x55; trigger with 0x66 valid; next d_valid 0x77. Required readout with out_ready=1: 0x44,0x55,0x66,0x77, indices 0..3, out_last on 0x77, first out_valid 1 cycle after entering READOUT.
- Partial fill, POST=0: write 0xA1,0xA2 then trigger alone. Required readout: exactly 2 beats 0xA1,0xA2, out_last on 0xA2, then busy=0.
- Backpressure: hold out_ready=0 for 5 cycles mid-readout. Required: out_data, out_index and out_last are unchanged and no entry is skipped or duplicated.
- Wrap across M=3 (non-power-of-two): write 7 samples 1..7, trigger with POST=0. Required readout: 5,6,7.
- Reset during READOUT after beat 1: out_valid=0 and busy=0 at the next edge. A later capture of 0x01 + trigger yields a single beat 0x01 with out_last=1.
- Macro defined: 3 triggers during POST/READOUT plus 1 trigger in empty CAPTURE. Required: ignored_trig=4, and the readout is unaffected.

Source files
------------

// File: rtl/dreg_snapshot_readout.sv
// Circular snapshot recorder: captures samples until a trigger plus POST more, then streams them oldest-first.
// Optional ignored-trigger counter output is enabled with `define DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN.
module dreg_snapshot_readout #(
    parameter int N    = 2,
    parameter int M    = 4,
    parameter int POST = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         d,
    input  logic                 d_valid,
    input  logic                 trigger,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [$clog2(M)-1:0] out_index,
    output logic                 busy
`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
    ,
    output logic [15:0]          ignored_trig
`endif
);

    localparam int IW = $clog2(M);
    localparam int FW = $clog2(M + 1);
    localparam int SW = FW + 1;

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_POST,
        ST_READOUT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [FW-1:0]   post_cnt_q, post_cnt_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [IW-1:0]   out_index_q, out_index_d;
    logic            busy_q, busy_d;
    logic            mem_we;
    logic [SW-1:0]   start_sum;
    logic [IW-1:0]   start_ptr;
    logic [N-1:0]    mem_q [M];

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(M - 1)) ? '0 : p + 1'b1;
    endfunction

    // Oldest entry = (wr_ptr - fill) mod M, computed wide to avoid relying on power-of-two wrap.
    always_comb begin
        if (SW'(wr_ptr_q) >= SW'(fill_q)) begin
            start_sum = SW'(wr_ptr_q) - SW'(fill_q);
        end else begin
            start_sum = SW'(wr_ptr_q) + SW'(M) - SW'(fill_q);
        end
        start_ptr = IW'(start_sum);
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        post_cnt_d  = post_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_index_d = out_index_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_CAPTURE: begin
                if (d_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                    fill_d   = (fill_q == FW'(M)) ? fill_q : fill_q + 1'b1;
                end
                if (trigger && (fill_q != '0 || d_valid)) begin
                    if (POST == 0) begin
                        state_d = ST_READOUT;
                    end else begin
                        state_d    = ST_POST;
                        post_cnt_d = FW'(POST);
                    end
                end
            end
            ST_POST: begin
                if (d_valid) begin
                    mem_we     = 1'b1;
                    wr_ptr_d   = ptr_inc(wr_ptr_q);
                    fill_d     = (fill_q == FW'(M)) ? fill_q : fill_q + 1'b1;
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == FW'(1)) begin
                        state_d = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[start_ptr];
                    out_index_d = '0;
                    out_last_d  = (fill_q == FW'(1));
                    rd_ptr_d    = ptr_inc(start_ptr);
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        fill_d      = '0;
                        state_d     = ST_CAPTURE;
                    end else begin
                        out_data_d  = mem_q[rd_ptr_q];
                        out_index_d = out_index_q + 1'b1;
                        out_last_d  = (FW'(out_index_q) + FW'(2) == fill_q);
                        rd_ptr_d    = ptr_inc(rd_ptr_q);
                    end
                end
            end
            default: state_d = ST_CAPTURE;
        endcase

        busy_d = (state_d != ST_CAPTURE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_CAPTURE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            post_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            post_cnt_q  <= post_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
            busy_q      <= busy_d;
        end
    end

    // Array contents survive reset; only the bookkeeping is cleared.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;

`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
    logic        trig_ignored;
    logic [15:0] ign_q, ign_d;

    always_comb begin
        trig_ignored = trigger && ((state_q != ST_CAPTURE) || (fill_q == '0 && !d_valid));
        ign_d        = ign_q;
        if (trig_ignored && ign_q != 16'hFFFF) begin
            ign_d = ign_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ign_q <= '0;
        end else begin
            ign_q <= ign_d;
        end
    end

    assign ignored_trig = ign_q;
`endif

endmodule

// File: tb/tb_dreg_snapshot_readout.sv
// Bench for dreg_snapshot_readout: three configurations share stimulus and are checked against a queue-style model.
// Define DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN to also exercise the ignored-trigger counter.
module tb_dreg_snapshot_readout;

    logic       clock = 1'b0;
    logic       reset, d_valid, trigger, out_ready;
    logic [7:0] d;

    logic [7:0] o_data [3];
    logic       o_valid [3];
    logic       o_last [3];
    logic       o_busy [3];
    logic [1:0] o_idx [3];
`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
    logic [15:0] o_ign [3];
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: per instance a history of the newest samples (index 0 = oldest).
    int         m_M [3] = '{4, 4, 3};
    int         m_P [3] = '{1, 0, 0};
    int         m_mode [3];
    int         m_hcnt [3];
    int         m_post [3];
    int         m_k [3];
    int         m_ign [3];
    bit         m_ev [3];
    logic [7:0] m_hist [3][4];

    typedef struct {
        bit         dv;
        logic [7:0] d;
        bit         tr;
        bit         rd;
        int         ev;
        int         ed;
        int         ei;
        int         el;
        int         eb;
    } vec_t;

    always #5 clock = ~clock;

    dreg_snapshot_readout #(.N(8), .M(4), .POST(1)) u_a (
        .clock(clock), .reset(reset), .d(d), .d_valid(d_valid), .trigger(trigger),
        .out_ready(out_ready), .out_data(o_data[0]), .out_valid(o_valid[0]),
        .out_last(o_last[0]), .out_index(o_idx[0]), .busy(o_busy[0])
`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
        , .ignored_trig(o_ign[0])
`endif
    );

    dreg_snapshot_readout #(.N(8), .M(4), .POST(0)) u_b (
        .clock(clock), .reset(reset), .d(d), .d_valid(d_valid), .trigger(trigger),
        .out_ready(out_ready), .out_data(o_data[1]), .out_valid(o_valid[1]),
        .out_last(o_last[1]), .out_index(o_idx[1]), .busy(o_busy[1])
`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
        , .ignored_trig(o_ign[1])
`endif
    );

    dreg_snapshot_readout #(.N(8), .M(3), .POST(0)) u_c (
        .clock(clock), .reset(reset), .d(d), .d_valid(d_valid), .trigger(trigger),
        .out_ready(out_ready), .out_data(o_data[2]), .out_valid(o_valid[2]),
        .out_last(o_last[2]), .out_index(o_idx[2]), .busy(o_busy[2])
`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
        , .ignored_trig(o_ign[2])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int i, input int ev, input int ed,
                           input int ei, input int el, input int eb);
        chk($sformatf("%s valid%0d", tag, i), 32'(o_valid[i]), ev);
        chk($sformatf("%s busy%0d", tag, i), 32'(o_busy[i]), eb);
        if (ev != 0) begin
            chk($sformatf("%s data%0d", tag, i), 32'(o_data[i]), ed);
            chk($sformatf("%s index%0d", tag, i), 32'(o_idx[i]), ei);
            chk($sformatf("%s last%0d", tag, i), 32'(o_last[i]), el);
        end
    endtask

    task automatic push(input int i, input logic [7:0] v);
        if (m_hcnt[i] < m_M[i]) begin
            m_hist[i][m_hcnt[i]] = v;
            m_hcnt[i]++;
        end else begin
            for (int j = 0; j < m_M[i] - 1; j++) m_hist[i][j] = m_hist[i][j+1];
            m_hist[i][m_M[i]-1] = v;
        end
    endtask

    // Modes: 0 capture, 1 post, 2 readout before first beat, 3 streaming.
    task automatic model_step(input int i);
        bit acc;
        if (reset) begin
            m_mode[i] = 0; m_hcnt[i] = 0; m_ev[i] = 1'b0; m_ign[i] = 0; m_k[i] = 0;
            return;
        end
        if (trigger && (m_mode[i] != 0 || (m_hcnt[i] == 0 && !d_valid)) && m_ign[i] < 65535)
            m_ign[i]++;
        case (m_mode[i])
            0: begin
                acc = trigger && (m_hcnt[i] > 0 || d_valid);
                if (d_valid) push(i, d);
                if (acc) begin
                    if (m_P[i] == 0) m_mode[i] = 2;
                    else begin m_mode[i] = 1; m_post[i] = m_P[i]; end
                end
            end
            1: if (d_valid) begin
                push(i, d);
                m_post[i]--;
                if (m_post[i] == 0) m_mode[i] = 2;
            end
            2: begin m_ev[i] = 1'b1; m_k[i] = 0; m_mode[i] = 3; end
            default: if (out_ready) begin
                if (m_k[i] == m_hcnt[i] - 1) begin
                    m_ev[i] = 1'b0; m_mode[i] = 0; m_hcnt[i] = 0;
                end else m_k[i]++;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clock);
        for (int i = 0; i < 3; i++) model_step(i);
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk_out("model", i, int'(m_ev[i]), int'(m_hist[i][m_k[i]]), m_k[i],
                        int'(m_k[i] == m_hcnt[i] - 1), int'(m_mode[i] != 0));
`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
                chk($sformatf("model ign%0d", i), 32'(o_ign[i]), m_ign[i]);
`endif
            end
        end
    end

    task automatic cyc(input bit rst, input bit dv, input logic [7:0] dd, input bit tr, input bit rd);
        @(negedge clock);
        reset = rst; d_valid = dv; d = dd; trigger = tr; out_ready = rd;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t tbl [12];
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 0, 0,     0, 0, 0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 0, 0,     0, 0, 0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 0, 0,     0, 0, 0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 0, 0,     0, 0, 0};
        tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 0, 0,     0, 0, 0};
        tbl[5]  = '{1'b1, 8'h66, 1'b1, 1'b1, 0, 0,     0, 0, 1};
        tbl[6]  = '{1'b1, 8'h77, 1'b0, 1'b1, 0, 0,     0, 0, 1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 'h44,  0, 0, 1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 'h55,  1, 0, 1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 'h66,  2, 0, 1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 'h77,  3, 1, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 0,     0, 0, 0};

        reset = 1'b1; d_valid = 1'b0; d = '0; trigger = 1'b0; out_ready = 1'b0;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_out("reset", i, 0, 0, 0, 0, 0);
            chk($sformatf("reset data%0d", i), 32'(o_data[i]), 0);
            chk($sformatf("reset index%0d", i), 32'(o_idx[i]), 0);
            chk($sformatf("reset last%0d", i), 32'(o_last[i]), 0);
`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
            chk($sformatf("reset ign%0d", i), 32'(o_ign[i]), 0);
`endif
        end

        // Full buffer with wrap and one post-trigger sample (instance A).
        for (int j = 0; j < 12; j++) begin
            cyc(1'b0, tbl[j].dv, tbl[j].d, tbl[j].tr, tbl[j].rd);
            chk_out($sformatf("tbl%0d", j), 0, tbl[j].ev, tbl[j].ed, tbl[j].ei, tbl[j].el, tbl[j].eb);
        end

        // Partial fill, POST=0 (instance B).
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk_out("partial trig", 1, 0, 0, 0, 0, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("partial b0", 1, 1, 'hA1, 0, 0, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("partial b1", 1, 1, 'hA2, 1, 1, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("partial end", 1, 0, 0, 0, 0, 0);

        // Backpressure mid-readout (instance A).
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int v = 'h10; v < 'h14; v++) cyc(1'b0, 1'b1, 8'(v), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h14, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h15, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_out("bp b0", 0, 1, 'h12, 0, 0, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("bp b1", 0, 1, 'h13, 1, 0, 1);
        for (int s = 0; s < 5; s++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk_out($sformatf("bp hold%0d", s), 0, 1, 'h13, 1, 0, 1);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("bp b2", 0, 1, 'h14, 2, 0, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("bp b3", 0, 1, 'h15, 3, 1, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("bp end", 0, 0, 0, 0, 0, 0);

        // Wrap on a non-power-of-two depth (instance C, M=3).
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int v = 1; v <= 7; v++) cyc(1'b0, 1'b1, 8'(v), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk_out("wrap trig", 2, 0, 0, 0, 0, 1);
        for (int b = 0; b < 3; b++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            chk_out($sformatf("wrap b%0d", b), 2, 1, 5 + b, b, int'(b == 2), 1);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("wrap end", 2, 0, 0, 0, 0, 0);

        // Reset during readout, then a single-entry capture (instance B).
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("rr b0", 1, 1, 'h21, 0, 0, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("rr b1", 1, 1, 'h22, 1, 1, 1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("rr reset", 1, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
        chk_out("rr trig", 1, 0, 0, 0, 0, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("rr single", 1, 1, 'h01, 0, 1, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("rr end", 1, 0, 0, 0, 0, 0);

`ifdef DREG_SNAPSHOT_IGNORED_TRIG_CNT_EN
        // Ignored triggers: one on empty capture, one in POST, two in READOUT (instance A).
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h32, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk_out("ign b0", 0, 1, 'h31, 0, 0, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int b = 1; b < 4; b++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            chk_out($sformatf("ign b%0d", b), 0, 1, 'h31 + b, b, int'(b == 3), 1);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out("ign end", 0, 0, 0, 0, 0, 0);
        chk("ign count", 32'(o_ign[0]), 4);
`endif

        // Randomized traffic with occasional resets, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
